// File: rtl/axi_ram_slave.sv
// AXI4 single-outstanding RAM responder: word-wide RAM with byte strobes,
// INCR/FIXED bursts, DECERR for out-of-range beats and SLVERR for malformed bursts.
module axi_ram_slave #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [3:0]  awcache,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic        bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic        arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [3:0]  arcache,
  input  logic        arvalid,
  output logic        arready,
  output logic        rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RFETCH, S_RDATA} state_e;

  state_e      state_q, state_d;
  logic        id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        bad_q, bad_d;
  logic        slverr_q, slverr_d;
  logic        decerr_q, decerr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;

  logic [31:0]       mem [DEPTH];
  logic              in_range;
  logic              last_beat;
  logic              mem_we;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       next_addr;
  logic              unused_cache;

  assign unused_cache = ^{awcache, arcache};

  assign in_range  = (addr_q >> ADDR_W) == 32'd0;
  assign widx      = addr_q[ADDR_W-1:2];
  assign last_beat = (cnt_q == len_q);
  // Malformed bursts (WRAP or oversize) are processed as FIXED.
  assign next_addr = (burst_q == 2'b01 && !bad_q) ? addr_q + (32'd1 << size_q) : addr_q;
  assign mem_we    = (state_q == S_WDATA) && wvalid && in_range;

  assign awready = (state_q == S_IDLE) && !reset;
  assign arready = (state_q == S_IDLE) && !awvalid && !reset;
  assign wready  = (state_q == S_WDATA);
  assign bvalid  = (state_q == S_WRESP);
  assign bid     = id_q;
  assign bresp   = (state_q != S_WRESP)     ? 2'b00 :
                   decerr_q                 ? 2'b11 :
                   (slverr_q || bad_q)      ? 2'b10 : 2'b00;
  assign rvalid  = (state_q == S_RDATA);
  assign rid     = id_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    burst_d  = burst_q;
    bad_d    = bad_q;
    slverr_d = slverr_q;
    decerr_d = decerr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    case (state_q)
      S_IDLE: begin
        if (awvalid) begin
          id_d     = awid;
          addr_d   = awaddr;
          len_d    = awlen;
          size_d   = awsize;
          burst_d  = awburst;
          bad_d    = (awburst == 2'b10) || (awsize > 3'd2);
          cnt_d    = 8'd0;
          slverr_d = 1'b0;
          decerr_d = 1'b0;
          state_d  = S_WDATA;
        end else if (arvalid) begin
          id_d     = arid;
          addr_d   = araddr;
          len_d    = arlen;
          size_d   = arsize;
          burst_d  = arburst;
          bad_d    = (arburst == 2'b10) || (arsize > 3'd2);
          cnt_d    = 8'd0;
          slverr_d = 1'b0;
          decerr_d = 1'b0;
          state_d  = S_RFETCH;
        end
      end
      S_WDATA: begin
        if (wvalid) begin
          if (!in_range) decerr_d = 1'b1;
          if (wlast != last_beat) slverr_d = 1'b1;
          if (last_beat) begin
            state_d = S_WRESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end
      S_WRESP: begin
        if (bready) state_d = S_IDLE;
      end
      S_RFETCH: begin
        rdata_d = in_range ? mem[widx] : 32'd0;
        rresp_d = !in_range ? 2'b11 : bad_q ? 2'b10 : 2'b00;
        rlast_d = last_beat;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        if (rready) begin
          if (rlast_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = next_addr;
            state_d = S_RFETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      id_q     <= 1'b0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'b00;
      bad_q    <= 1'b0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      bad_q    <= bad_d;
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: a shadow RAM model predicts B and R
// responses at stimulus time; monitors pop and compare as the DUT responds.
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic        rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  axi_ram_slave #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {logic id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

  int n_cmp = 0;
  int n_err = 0;
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [31:0] mdl [0:1023];
  logic [31:0] bd [0:255];
  logic [3:0]  bs [0:255];
  logic        bl [0:255];

  task automatic idle_inputs();
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awcache = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arcache = 0; arvalid = 0;
    rready = 0;
  endtask

  task automatic set_beats(input int n, input logic [31:0] base, input logic [3:0] strb);
    for (int i = 0; i < n; i++) begin
      bd[i] = base + 32'(i);
      bs[i] = strb;
      bl[i] = (i == n - 1);
    end
  endtask

  task automatic model_write(input logic id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic bad, dec, slv;
    b_exp_t e;
    a = addr;
    bad = (burst == 2'b10) || (size > 3'd2);
    dec = 1'b0;
    slv = bad;
    for (int i = 0; i <= len; i++) begin
      if (bl[i] != (i == len)) slv = 1'b1;
      if (a >= 32'h1000) dec = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (bs[i][b]) mdl[a[11:2]][8*b +: 8] = bd[i][8*b +: 8];
      if (burst == 2'b01 && !bad) a = a + (32'd1 << size);
    end
    e.id = id;
    e.resp = dec ? 2'b11 : slv ? 2'b10 : 2'b00;
    b_q.push_back(e);
  endtask

  task automatic model_read(input logic id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic bad;
    r_exp_t e;
    a = addr;
    bad = (burst == 2'b10) || (size > 3'd2);
    for (int i = 0; i <= len; i++) begin
      e.id = id;
      e.last = (i == len);
      if (a >= 32'h1000) begin
        e.data = 32'd0;
        e.resp = 2'b11;
      end else begin
        e.data = mdl[a[11:2]];
        e.resp = bad ? 2'b10 : 2'b00;
      end
      r_q.push_back(e);
      if (burst == 2'b01 && !bad) a = a + (32'd1 << size);
    end
  endtask

  task automatic aw_hs(input logic id, input logic [31:0] addr, input int len,
                       input logic [2:0] size, input logic [1:0] burst);
    int k;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1;
    k = 0;
    #1;
    while (!awready && k < 50) begin @(negedge clk); #1; k++; end
    if (!awready) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout: awready=%b required 1", awready);
    end
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  task automatic w_beat(input int i);
    int k;
    @(negedge clk);
    wdata = bd[i]; wstrb = bs[i]; wlast = bl[i]; wvalid = 1;
    k = 0;
    #1;
    while (!wready && k < 50) begin @(negedge clk); #1; k++; end
    if (!wready) begin
      n_cmp++; n_err++;
      $display("FAIL w_timeout: wready=%b required 1", wready);
    end
    @(posedge clk); #1;
    wvalid = 0;
  endtask

  task automatic ar_hs(input logic id, input logic [31:0] addr, input int len,
                       input logic [2:0] size, input logic [1:0] burst);
    int k;
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1;
    k = 0;
    #1;
    while (!arready && k < 50) begin @(negedge clk); #1; k++; end
    if (!arready) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout: arready=%b required 1", arready);
    end
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic drain_b();
    b_exp_t e;
    int k;
    k = 0;
    while (!bvalid && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (!bvalid || b_q.size() == 0) begin
      n_err++;
      $display("FAIL b_response: bvalid=%b queued=%0d required bvalid 1 with one queued", bvalid, b_q.size());
      b_q.delete();
      return;
    end
    e = b_q.pop_front();
    if ({bid, bresp} !== {e.id, e.resp}) begin
      n_err++;
      $display("FAIL b_payload: bid=%b bresp=%b required bid=%b bresp=%b", bid, bresp, e.id, e.resp);
    end
    @(negedge clk); bready = 1;
    @(posedge clk); #1; bready = 0;
  endtask

  task automatic drain_r(input int hold);
    r_exp_t e;
    int k;
    while (r_q.size() > 0) begin
      k = 0;
      while (!rvalid && k < 50) begin @(negedge clk); k++; end
      e = r_q.pop_front();
      n_cmp++;
      if (!rvalid) begin
        n_err++;
        $display("FAIL r_timeout: rvalid=%b required 1", rvalid);
        r_q.delete();
        return;
      end
      if ({rid, rdata, rresp, rlast} !== {e.id, e.data, e.resp, e.last}) begin
        n_err++;
        $display("FAIL r_payload: rid=%b rdata=%h rresp=%b rlast=%b required rid=%b rdata=%h rresp=%b rlast=%b",
                 rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
      end
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({rvalid, rid, rdata, rresp, rlast} !== {1'b1, e.id, e.data, e.resp, e.last}) begin
          n_err++;
          $display("FAIL r_stall_stable: cycle %0d rvalid=%b rdata=%h rresp=%b rlast=%b required 1 %h %b %b",
                   c, rvalid, rdata, rresp, rlast, e.data, e.resp, e.last);
        end
      end
      @(negedge clk); rready = 1;
      @(posedge clk); #1; rready = 0;
      if (!e.last) begin
        n_cmp++;
        if (rvalid !== 1'b0) begin
          n_err++;
          $display("FAIL r_bubble: rvalid=%b required 0", rvalid);
        end
      end
    end
  endtask

  task automatic wr_txn(input logic id, input logic [31:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    model_write(id, addr, len, size, burst);
    aw_hs(id, addr, len, size, burst);
    for (int i = 0; i <= len; i++) w_beat(i);
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL b_latency: bvalid=%b one cycle after last W, required 1", bvalid);
    end
    drain_b();
  endtask

  task automatic rd_txn(input logic id, input logic [31:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst, input int hold);
    model_read(id, addr, len, size, burst);
    ar_hs(id, addr, len, size, burst);
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL r_latency_early: rvalid=%b one cycle after AR, required 0", rvalid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL r_latency: rvalid=%b two cycles after AR, required 1", rvalid);
    end
    drain_r(hold);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    awvalid = 1; arvalid = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid, rlast, bid, rid, bresp, rresp, rdata} !== 44'd0) begin
      n_err++;
      $display("FAIL reset_outputs: aw=%b w=%b ar=%b b=%b r=%b rlast=%b bid=%b rid=%b bresp=%b rresp=%b rdata=%h required all 0",
               awready, wready, arready, bvalid, rvalid, rlast, bid, rid, bresp, rresp, rdata);
    end
    awvalid = 0; arvalid = 0;
    reset = 0;
    #1;
    n_cmp++;
    if ({awready, arready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release: awready=%b arready=%b required 1 1", awready, arready);
    end
  endtask

  task automatic test_single();
    bd[0] = 32'hDEADBEEF; bs[0] = 4'hF; bl[0] = 1'b1;
    wr_txn(1'b1, 32'h10, 0, 3'd2, 2'b01);
    rd_txn(1'b1, 32'h10, 0, 3'd2, 2'b01, 0);
  endtask

  task automatic test_incr_burst();
    set_beats(4, 32'd1, 4'hF);
    wr_txn(1'b0, 32'h100, 3, 3'd2, 2'b01);
    rd_txn(1'b0, 32'h100, 3, 3'd2, 2'b01, 0);
  endtask

  task automatic test_strobes();
    bd[0] = 32'h11223344; bs[0] = 4'hF; bl[0] = 1'b1;
    wr_txn(1'b0, 32'h20, 0, 3'd2, 2'b01);
    bd[0] = 32'hAABBCCDD; bs[0] = 4'b0101;
    wr_txn(1'b1, 32'h20, 0, 3'd2, 2'b01);
    rd_txn(1'b1, 32'h20, 0, 3'd2, 2'b01, 0);
  endtask

  task automatic test_errors();
    bd[0] = 32'hCAFEF00D; bs[0] = 4'hF; bl[0] = 1'b1;
    wr_txn(1'b0, 32'h0, 0, 3'd2, 2'b01);
    bd[0] = 32'h12345678;
    wr_txn(1'b1, 32'h1000, 0, 3'd2, 2'b01);
    rd_txn(1'b0, 32'h0, 0, 3'd2, 2'b01, 0);
    rd_txn(1'b1, 32'h1000, 0, 3'd2, 2'b01, 0);
    bd[0] = 32'hA1A1A1A1; bs[0] = 4'hF; bl[0] = 1'b1;
    bd[1] = 32'hB2B2B2B2; bs[1] = 4'hF; bl[1] = 1'b0;
    wr_txn(1'b0, 32'h40, 1, 3'd2, 2'b01);
    rd_txn(1'b0, 32'h40, 1, 3'd2, 2'b01, 0);
    bd[0] = 32'h55555555; bl[0] = 1'b0;
    bd[1] = 32'h66666666; bl[1] = 1'b1;
    wr_txn(1'b1, 32'h50, 1, 3'd2, 2'b10);
    rd_txn(1'b1, 32'h50, 1, 3'd2, 2'b10, 0);
  endtask

  task automatic test_contention();
    @(negedge clk);
    awid = 0; awaddr = 32'h30; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1;
    arid = 1; araddr = 32'h30; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
    #1;
    n_cmp++;
    if ({awready, arready} !== 2'b10) begin
      n_err++;
      $display("FAIL contention: awready=%b arready=%b required 1 0", awready, arready);
    end
    bd[0] = 32'h0BADF00D; bs[0] = 4'hF; bl[0] = 1'b1;
    model_write(1'b0, 32'h30, 0, 3'd2, 2'b01);
    @(posedge clk); #1;
    awvalid = 0;
    w_beat(0);
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL contention_b_latency: bvalid=%b required 1", bvalid);
    end
    drain_b();
    rd_txn(1'b1, 32'h30, 0, 3'd2, 2'b01, 5);
  endtask

  task automatic test_reset_midburst();
    set_beats(4, 32'h10, 4'hF);
    wr_txn(1'b0, 32'h200, 3, 3'd2, 2'b01);
    set_beats(4, 32'hA0, 4'hF);
    aw_hs(1'b1, 32'h200, 3, 3'd2, 2'b01);
    w_beat(0);
    w_beat(1);
    mdl[32'h200 >> 2] = bd[0];
    mdl[32'h204 >> 2] = bd[1];
    @(negedge clk);
    wdata = bd[2]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1;
    #1 reset = 1;
    #1;
    n_cmp++;
    if ({bvalid, wready, awready} !== 3'b000) begin
      n_err++;
      $display("FAIL midburst_reset: bvalid=%b wready=%b awready=%b required 0 0 0", bvalid, wready, awready);
    end
    @(negedge clk);
    wvalid = 0;
    reset = 0;
    #1;
    n_cmp++;
    if ({awready, bvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL midburst_idle: awready=%b bvalid=%b required 1 0", awready, bvalid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bvalid !== 1'b0) begin
        n_err++;
        $display("FAIL midburst_no_resp: bvalid=%b required 0", bvalid);
      end
    end
    rd_txn(1'b0, 32'h200, 3, 3'd2, 2'b01, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_strobes();
    test_errors();
    test_contention();
    test_reset_midburst();
    n_cmp++;
    if (b_q.size() != 0 || r_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: b=%0d r=%0d required 0 0", b_q.size(), r_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12; RAM holds 2^(ADDR_W-2) 32-bit words, byte range [0, 2^ADDR_W).
REQ-002 SHALL have one clock and an asynchronous, active-high reset, named as below:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have the following ports, one channel payload per line:
- awid/awaddr/awlen/awsize/awburst/awcache  input  1/32/8/3/2/4  write address payload; awcache ignored.
- awvalid  input  1  write address valid.
- awready  output  1  write address accepted.
- wdata/wstrb/wlast  input  32/4/1  write data payload.
- wvalid  input  1  write data valid.
- wready  output  1  write data accepted.
- bid/bresp  output  1/2  write response payload.
- bvalid  output  1  write response valid.
- bready  input  1  write response accepted.
- arid/araddr/arlen/arsize/arburst/arcache  input  1/32/8/3/2/4  read address payload; arcache ignored.
- arvalid  input  1  read address valid.
- arready  output  1  read address accepted.
- rid/rdata/rresp/rlast  output  1/32/2/1  read data payload.
- rvalid  output  1  read data valid.
- rready  input  1  read data accepted.

Function
REQ-004 SHALL be an AXI4 responder with one outstanding transaction total, FSM states IDLE, WDATA, WRESP, RFETCH, RDATA.
REQ-005 SHALL drive awready=1 only in IDLE; arready=1 only in IDLE with awvalid=0, so write wins on simultaneous AW/AR.
REQ-006 SHALL, on AW handshake, latch id, addr, len, size and burst, clear the beat counter, and go IDLE->WDATA.
REQ-007 SHALL, in WDATA, drive wready=1, and on each W handshake write each byte lane whose wstrb bit is set at word addr[ADDR_W-1:2].
REQ-008 SHALL advance the address after each beat by 1<<size when burst=INCR(01), and hold it when burst=FIXED(00).
REQ-009 SHALL end the write on the beat where counter==len and go to WRESP, independent of wlast.
REQ-010 SHALL set the sticky error flag SLVERR when wlast differs from (counter==len) on any beat.
REQ-011 SHALL, in WRESP, hold bvalid=1 and bid=latched id until bready, then go to IDLE.
REQ-012 SHALL give bresp priority DECERR(11) > SLVERR(10) > OKAY(00).
REQ-013 SHALL set DECERR when any beat address is >= 2^ADDR_W; that beat's write is suppressed.
REQ-014 SHALL treat burst=WRAP(10) or size>2 as SLVERR, process those transactions as FIXED, and still run the full beat count.
REQ-015 SHALL, on AR handshake, latch payload, go to RFETCH, read RAM synchronously, and load the rdata register, then go to RFETCH->RDATA.
REQ-016 SHALL, in RDATA, drive rvalid=1 and rid=latched id, with rlast=(counter==len) and rresp per beat (DECERR if out of range, else SLVERR per REQ-014, else OKAY).
REQ-017 SHALL return rdata=0 on out-of-range beats.
REQ-018 SHALL hold rid/rdata/rresp/rlast stable while rvalid=1 and rready=0.
REQ-019 SHALL, on R handshake, go to IDLE if rlast; otherwise advance the address and counter and go to RFETCH (one bubble cycle per beat).
REQ-020 SHALL have these latencies: AR handshake to first rvalid = 2 cycles; last W handshake to bvalid = 1 cycle.
REQ-021 SHALL support len up to 255; the counter is 8 bits and never wraps within a burst.
REQ-022 SHALL allow a byte address to wrap at 2^32 with no special handling; the wrapped address is then range-checked.

Reset
REQ-023 SHALL, while reset=1, force state=IDLE and awready=wready=arready=bvalid=rvalid=rlast=0, with bid=rid=0, bresp=rresp=00, rdata=0, counter=0 and error flags clear.
REQ-024 SHALL, when reset asserts mid-burst, abort the burst with no response, leaving already-written beats in RAM.
REQ-025 SHALL not reset RAM contents.

Verification
REQ-026 SHALL cover single write: AW(id=1, addr=0x10, len=0, size=2, INCR) plus W(0xDEADBEEF, wstrb=1111, wlast=1) -> bvalid 1 cycle later, bid=1, bresp=00; then AR(0x10) -> rdata=0xDEADBEEF, rlast=1, rresp=00, rvalid 2 cycles after AR.
REQ-027 SHALL cover INCR burst: write len=3 at 0x100 with data 1,2,3,4, then read back len=3 -> four beats 1,2,3,4, rlast only on beat 4.
REQ-028 SHALL cover byte strobes: preload 0x11223344 at 0x20, write 0xAABBCCDD with wstrb=0101 -> readback 0x11BB33DD.
REQ-029 SHALL cover errors: write at 0x1000 with ADDR_W=12 -> bresp=11 and RAM unchanged; len=1 with wlast on beat 1 -> bresp=10, both beats written.
REQ-030 SHALL cover contention/backpressure: awvalid and arvalid in the same cycle -> awready=1, arready=0; hold rready=0 for 5 cycles -> R payload stable, and a single beat completes on rready.
REQ-031 SHALL cover reset mid-burst: assert reset during beat 2 of a len=3 write -> no bvalid, IDLE next; beats 0-1 in RAM, beats 2-3 unchanged.
